// File: rtl/mem_txn_responder_if.sv
// rtl/mem_txn_responder_if.sv - proc2mem command / mem2proc response bus
interface mem_txn_responder_if;
    logic [1:0]  proc2mem_command;
    logic [63:0] proc2mem_address;
    logic [63:0] proc2mem_data;
    logic [3:0]  mem2proc_reponse;
    logic [63:0] mem2proc_data;
    logic [3:0]  mem2proc_tag;

    modport master (
        output proc2mem_command, proc2mem_address, proc2mem_data,
        input  mem2proc_reponse, mem2proc_data, mem2proc_tag
    );

    modport slave (
        input  proc2mem_command, proc2mem_address, proc2mem_data,
        output mem2proc_reponse, mem2proc_data, mem2proc_tag
    );
endinterface

// File: rtl/mem_txn_responder.sv
// rtl/mem_txn_responder.sv - tagged fixed-latency in-order memory model
module mem_txn_responder #(
    parameter int unsigned LATENCY         = 4,
    parameter int unsigned NUM_OUTSTANDING = 4,
    parameter int unsigned DEPTH           = 256
) (
    input  logic               clock,
    input  logic               reset,
    mem_txn_responder_if.slave bus
);
    localparam int IW = $clog2(DEPTH);
    localparam int PW = (NUM_OUTSTANDING > 1) ? $clog2(NUM_OUTSTANDING) : 1;
    localparam int OW = $clog2(NUM_OUTSTANDING + 1);
    localparam int CW = $clog2(LATENCY + 1);

    typedef struct packed {
        logic [3:0]    tag;
        logic          is_store;
        logic [IW-1:0] idx;
        logic [63:0]   data;
        logic [CW-1:0] cd;
    } entry_t;

    entry_t        fifo_q [NUM_OUTSTANDING];
    entry_t        fifo_d [NUM_OUTSTANDING];
    logic [PW-1:0] head_q, head_d, tail_q, tail_d;
    logic [OW-1:0] fcnt_q, fcnt_d, occ_q, occ_d;
    logic [3:0]    tag_q, tag_d, out_tag_q, out_tag_d;
    logic [63:0]   out_data_q, out_data_d;
    logic [63:0]   mem_q [DEPTH];

    logic          is_cmd, accept, fire;
    logic [IW-1:0] cmd_idx;
    entry_t        head;
    logic          unused_addr;

    assign unused_addr = ^{bus.proc2mem_address[63:IW+3], bus.proc2mem_address[2:0]};
    assign cmd_idx = bus.proc2mem_address[IW+2:3];
    assign is_cmd  = (bus.proc2mem_command == 2'b01) || (bus.proc2mem_command == 2'b10);
    // Occupancy only drops after the completion has been presented, so a
    // completing slot is never reused in the same cycle.
    assign accept  = !reset && is_cmd && (occ_q < OW'(NUM_OUTSTANDING));
    assign head    = fifo_q[head_q];
    // Head pops one edge early so its result is registered for the completion cycle.
    assign fire    = (fcnt_q != '0) && (head.cd == CW'(1));

    assign bus.mem2proc_reponse = accept ? tag_q : 4'd0;
    assign bus.mem2proc_tag     = out_tag_q;
    assign bus.mem2proc_data    = out_data_q;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(NUM_OUTSTANDING - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        fifo_d     = fifo_q;
        head_d     = head_q;
        tail_d     = tail_q;
        tag_d      = tag_q;
        out_tag_d  = 4'd0;
        out_data_d = 64'd0;
        for (int i = 0; i < int'(NUM_OUTSTANDING); i++) begin
            if (fifo_d[i].cd != '0) begin
                fifo_d[i].cd = fifo_d[i].cd - CW'(1);
            end
        end
        if (accept) begin
            fifo_d[tail_q] = '{tag: tag_q, is_store: bus.proc2mem_command[1],
                               idx: cmd_idx, data: bus.proc2mem_data,
                               cd: CW'(LATENCY - 1)};
            tail_d = ptr_inc(tail_q);
            tag_d  = (tag_q == 4'd15) ? 4'd1 : tag_q + 4'd1;
        end
        if (fire) begin
            head_d     = ptr_inc(head_q);
            out_tag_d  = head.tag;
            out_data_d = head.is_store ? 64'd0 : mem_q[head.idx];
        end
        fcnt_d = fcnt_q + OW'(accept) - OW'(fire);
        occ_d  = occ_q + OW'(accept) - OW'(out_tag_q != 4'd0);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < int'(NUM_OUTSTANDING); i++) begin
                fifo_q[i] <= '0;
            end
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
            head_q     <= '0;
            tail_q     <= '0;
            fcnt_q     <= '0;
            occ_q      <= '0;
            tag_q      <= 4'd1;
            out_tag_q  <= 4'd0;
            out_data_q <= 64'd0;
        end else begin
            fifo_q     <= fifo_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            fcnt_q     <= fcnt_d;
            occ_q      <= occ_d;
            tag_q      <= tag_d;
            out_tag_q  <= out_tag_d;
            out_data_q <= out_data_d;
            if (fire && head.is_store) begin
                mem_q[head.idx] <= head.data;
            end
        end
    end
endmodule

// File: tb/tb_mem_txn_responder.sv
// tb/tb_mem_txn_responder.sv - scoreboard bench for mem_txn_responder
module tb_mem_txn_responder;
    localparam int LAT = 4;

    logic clock = 1'b0;
    logic reset = 1'b1;
    int   cyc = 0;
    int   vectors = 0;
    int   miscompares = 0;

    typedef struct {
        logic [3:0]  tag;
        logic [63:0] data;
        int          cyc;
    } exp_t;
    exp_t sb [$];

    mem_txn_responder_if bus ();

    mem_txn_responder #(.LATENCY(LAT), .NUM_OUTSTANDING(4), .DEPTH(256)) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    function automatic void chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %h, expected %h (cycle %0d)", nm, act, exp, cyc);
        end
    endfunction

    // Monitor: every presented completion must match the oldest expected one.
    always @(negedge clock) begin
        if (!reset) begin
            if (bus.mem2proc_tag != 4'd0) begin
                if (sb.size() == 0) begin
                    chk("unexpected_completion", 64'(bus.mem2proc_tag), 64'd0);
                end else begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("cpl_tag", 64'(bus.mem2proc_tag), 64'(e.tag));
                    chk("cpl_data", bus.mem2proc_data, e.data);
                    chk("cpl_cycle", 64'(cyc), 64'(e.cyc));
                end
            end else begin
                chk("idle_data", bus.mem2proc_data, 64'd0);
            end
        end
    end

    task automatic step(input logic [1:0] cmd, input logic [63:0] a, input logic [63:0] d,
                        input logic [3:0] er, input bit push, input logic [63:0] ed,
                        input string nm);
        exp_t e;
        bus.proc2mem_command = cmd;
        bus.proc2mem_address = a;
        bus.proc2mem_data    = d;
        @(negedge clock);
        chk(nm, 64'(bus.mem2proc_reponse), 64'(er));
        if (push && er != 4'd0) begin
            e.tag  = er;
            e.data = ed;
            e.cyc  = cyc + LAT;
            sb.push_back(e);
        end
        @(posedge clock);
        #1;
        bus.proc2mem_command = 2'b00;
    endtask

    task automatic idle(input int n);
        bus.proc2mem_command = 2'b00;
        repeat (n) begin
            @(posedge clock);
            #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        bus.proc2mem_command = 2'b01;
        bus.proc2mem_address = 64'h0;
        @(negedge clock);
        chk("resp_in_reset", 64'(bus.mem2proc_reponse), 64'd0);
        @(posedge clock);
        #1;
        @(negedge clock);
        chk("reset_tag", 64'(bus.mem2proc_tag), 64'd0);
        chk("reset_data", bus.mem2proc_data, 64'd0);
        @(posedge clock);
        #1;
        reset = 1'b0;
        bus.proc2mem_command = 2'b00;
        sb.delete();
    endtask

    initial begin
        bus.proc2mem_command = 2'b00;
        bus.proc2mem_address = 64'h0;
        bus.proc2mem_data    = 64'h0;
        @(posedge clock);
        #1;
        do_reset();

        // Store then load the same word
        step(2'b10, 64'h40, 64'hDEADBEEF_CAFEF00D, 4'd1, 1, 64'h0, "st40_resp");
        step(2'b01, 64'h40, 64'h0, 4'd2, 1, 64'hDEADBEEF_CAFEF00D, "ld40_resp");
        idle(8);

        // Outstanding limit: fifth is rejected, re-issue lands the cycle after tag 1
        do_reset();
        for (int i = 0; i < 4; i++) begin
            step(2'b01, 64'h100, 64'h0, 4'(i + 1), 1, 64'h0, "full_resp");
        end
        step(2'b01, 64'h100, 64'h0, 4'd0, 1, 64'h0, "full_reject");
        step(2'b01, 64'h100, 64'h0, 4'd5, 1, 64'h0, "full_reissue");
        idle(8);

        // Tag wrap skips zero
        do_reset();
        for (int i = 0; i < 16; i++) begin
            step(2'b01, 64'(i * 8), 64'h0, (i == 15) ? 4'd1 : 4'(i + 1), 1, 64'h0, "wrap_resp");
            idle(4);
        end
        idle(2);

        // Back-to-back store/load same index
        do_reset();
        step(2'b10, 64'h8, 64'h1234, 4'd1, 1, 64'h0, "b2b_st_resp");
        step(2'b01, 64'h8, 64'h0, 4'd2, 1, 64'h1234, "b2b_ld_resp");
        idle(8);

        // Reset mid-flight drops the transaction and restarts tags
        do_reset();
        step(2'b01, 64'h0, 64'h0, 4'd1, 0, 64'h0, "mid_ld_resp");
        idle(1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        idle(5);
        step(2'b01, 64'h0, 64'h0, 4'd1, 1, 64'h0, "post_rst_resp");
        idle(6);

        // Address aliasing and the reserved command code
        do_reset();
        step(2'b10, 64'h0, 64'h55, 4'd1, 1, 64'h0, "alias_st_resp");
        step(2'b01, 64'h800, 64'h0, 4'd2, 1, 64'h55, "alias_ld_resp");
        step(2'b11, 64'h0, 64'h0, 4'd0, 1, 64'h0, "cmd11_resp");
        step(2'b01, 64'h0, 64'h0, 4'd3, 1, 64'h55, "after11_resp");
        idle(8);

        chk("sb_drained", 64'(sb.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/mem_txn_responder.md
Name: mem_txn_responder

Overview:
Tagged, fixed-latency memory model that sits directly downstream of the encrypting datapath on the proc2mem/mem2proc bus. It accepts load and store commands and acknowledges each accepted command with a non-zero transaction tag in the same cycle. After a fixed latency it reports completion with that tag, returning read data for loads. It holds a small 64-bit backing store and bounds the number of in-flight transactions, so the datapath's stall-until-resolved handshake can be exercised.

Parameters:
LATENCY, 4, cycles from command acceptance to completion; legal range 2..16
NUM_OUTSTANDING, 4, maximum in-flight transactions; legal range 1..15
DEPTH, 256, number of 64-bit words in the backing store; power of two

Ports:
clock  input  1  rising-edge clock
reset  input  1  synchronous, active-high reset
proc2mem_command  input  2  00 none, 01 load, 10 store, 11 treated as none
proc2mem_address  input  64  byte address; word index = address[log2(DEPTH)+2:3]; upper bits ignored (wrap)
proc2mem_data  input  64  store data, sampled with the command
mem2proc_reponse  output  4  combinational; 0 = rejected or no command, else tag assigned this cycle
mem2proc_data  output  64  registered; load data, valid when mem2proc_tag != 0
mem2proc_tag  output  4  registered; 0 = no completion, else tag of the completing transaction

Behaviour:
- Reset: all state clears on the clock edge while reset is high. mem2proc_tag = 0, mem2proc_data = 0, occupancy = 0, next tag = 1, all backing-store words = 0. mem2proc_reponse = 0 while reset is high.
- Accept rule: a load or store is accepted iff reset is low and occupancy < NUM_OUTSTANDING, where occupancy is the pre-edge value.
  - A completion in the same cycle does not free a slot for that cycle; there is no bypass.
  - A rejected command has no side effects. The requester must re-issue it.
- Response: when a command is accepted, mem2proc_reponse = current next-tag in that cycle. Otherwise it is 0.
- Tag allocation: next tag advances on each accept. The sequence is 1,2,...,15,1 (0 is skipped).
- Queue: in-order FIFO of {tag, is_store, index, data, countdown}. Each entry's countdown is loaded with LATENCY-1 on accept and decrements every cycle.
- Completion: occurs when the head entry's countdown reaches 0. Timing is as follows.
  - A command accepted in cycle T completes with mem2proc_tag = its tag during cycle T+LATENCY, for exactly one cycle.
  - At most one completion per cycle; the fixed latency and one accept per cycle guarantee this.
- Load completion: mem2proc_data = mem[index], read at completion time.
- Store completion: mem[index] <= data at the completion edge. mem2proc_data = 0 and mem2proc_tag = the store's tag.
- Ordering: in-order completion. A load accepted after a store to the same index returns the stored value. A load accepted before that store returns the old value.
- No-completion cycles: mem2proc_tag = 0 and mem2proc_data = 0.
- Simultaneous accept and completion: occupancy is unchanged.
- Reset mid-operation: all in-flight transactions are discarded and no completion is reported for them. The tag sequence restarts at 1 and memory clears.
- Code 11: ignored, with response 0.
- Address wrap: the index uses only bits [log2(DEPTH)+2:3]. With DEPTH=256, addresses 0x0 and 0x800 alias.

Test Plan:
- Reset, then store 0xDEADBEEF_CAFEF00D to addr 0x40 at cycle 0 -> response=1 in cycle 0; tag=1, data=0 in cycle 4. Then load addr 0x40 -> response=2; cycle+4 gives tag=2, data=0xDEADBEEF_CAFEF00D.
- Issue 5 back-to-back loads with defaults -> responses 1,2,3,4,0. The fifth is accepted only after re-issue in the cycle after tag 1 completes (not in the same cycle).
- Issue 16 sequential accepted commands, each after the previous completes -> tags 1..15 then 1; tag 0 never appears.
- Back-to-back store addr 0x8 value 0x1234 then load addr 0x8 -> the load completes one cycle after the store, with data 0x1234.
- Accept a load at cycle 0, assert reset at cycle 2 -> no tag in cycle 4; the next accept after reset returns response=1.
- Store 0x55 to addr 0x0, then load addr 0x800 (DEPTH=256) -> data 0x55. Command 11 -> response 0 and no completion.
